// File: rtl/rcv_slicer_4ask_if.sv
// Sample-in / decision-out bundle for the 4-ASK receive slicer.
// The slave modport faces the slicer; the master modport faces the sample source and decision sink.
interface rcv_slicer_4ask_if #(
  parameter int WIDTH = 18,
  parameter int SPS   = 4
);
  localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;

  logic                    sam_clk_en;
  logic                    sym_clk_en;
  logic signed [WIDTH-1:0] x_in;
  logic [PW-1:0]           phase_sel;
  logic [1:0]              sym_out;
  logic                    sym_valid;
  logic signed [WIDTH-1:0] ref_level;
  logic                    ref_update;
  logic signed [WIDTH-1:0] err;

  modport slave (
    input  sam_clk_en, sym_clk_en, x_in, phase_sel,
    output sym_out, sym_valid, ref_level, ref_update, err
  );

  modport master (
    output sam_clk_en, sym_clk_en, x_in, phase_sel,
    input  sym_out, sym_valid, ref_level, ref_update, err
  );
endinterface

// File: rtl/rcv_slicer_4ask.sv
// 4-ASK receive slicer: picks one sample per symbol, slices it to 2 bits and tracks 2a by block-averaging |x|.
// Define RCV_SLICER_ERR_EN to build the slicer-error datapath; otherwise err is tied to zero.
module rcv_slicer_4ask #(
  parameter int WIDTH    = 18,
  parameter int SPS      = 4,
  parameter int ACC_LOG2 = 7,
  parameter int REF_INIT = 49152
) (
  input logic              sys_clk,
  input logic              reset,
  rcv_slicer_4ask_if.slave bus
);
  localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int AW = WIDTH + ACC_LOG2;
  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PW-1:0] PH_LAST      = PW'(SPS - 1);
  localparam logic [PW-1:0] PH_AFTER_SYM = (SPS > 1) ? PW'(1) : PW'(0);

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1]) begin
      return v[WIDTH] ? MIN_NEG : MAX_POS;
    end
    return v[WIDTH-1:0];
  endfunction

  // Phase tracking and capture
  logic [PW-1:0]           r_phase;
  logic [PW-1:0]           w_phase;
  logic                    w_capture;
  logic signed [WIDTH-1:0] r_x_sym;
  logic                    r_cap_v;

  // The symbol strobe marks phase 0 itself, so the counter already points at phase 1 afterwards.
  assign w_phase   = bus.sym_clk_en ? PW'(0) : r_phase;
  assign w_capture = bus.sam_clk_en && (w_phase == bus.phase_sel);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (bus.sam_clk_en) begin
      if (bus.sym_clk_en) begin
        r_phase <= PH_AFTER_SYM;
      end else if (r_phase == PH_LAST) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + PW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_x_sym <= '0;
      r_cap_v <= 1'b0;
    end else begin
      r_cap_v <= w_capture;
      if (w_capture) begin
        r_x_sym <= bus.x_in;
      end
    end
  end

  // Decision datapath
  logic signed [WIDTH-1:0] r_ref;
  logic signed [WIDTH-1:0] w_ax;
  logic signed [WIDTH-1:0] w_half;
  logic signed [WIDTH-1:0] w_three;
  logic                    w_neg;
  logic                    w_outer;
  logic [1:0]              w_sym;

  assign w_neg   = r_x_sym[WIDTH-1];
  assign w_ax    = (r_x_sym == MIN_NEG) ? MAX_POS : (w_neg ? -r_x_sym : r_x_sym);
  assign w_half  = r_ref >>> 1;
  assign w_three = sat({r_ref[WIDTH-1], r_ref} + {w_half[WIDTH-1], w_half});
  assign w_outer = (w_ax >= r_ref);
  assign w_sym   = {~w_neg, w_neg ? ~w_outer : w_outer};

  // Reference estimator
  logic [AW-1:0]       r_acc;
  logic [AW-1:0]       w_acc_sum;
  logic [ACC_LOG2-1:0] r_cnt;
  logic                w_cnt_last;
  logic [1:0]          r_sym_out;
  logic                r_sym_valid;
  logic                r_ref_update;

  assign w_acc_sum  = r_acc + {{ACC_LOG2{1'b0}}, w_ax};
  assign w_cnt_last = &r_cnt;

  // The decision on an updating edge still reads the old r_ref; the new level applies next symbol.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_sym_out    <= 2'b00;
      r_sym_valid  <= 1'b0;
      r_ref        <= WIDTH'(REF_INIT);
      r_ref_update <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
    end else begin
      r_sym_valid  <= r_cap_v;
      r_ref_update <= 1'b0;
      if (r_cap_v) begin
        r_sym_out <= w_sym;
        if (w_cnt_last) begin
          r_ref        <= signed'(w_acc_sum[AW-1:ACC_LOG2]);
          r_acc        <= '0;
          r_cnt        <= '0;
          r_ref_update <= 1'b1;
        end else begin
          r_acc <= w_acc_sum;
          r_cnt <= r_cnt + ACC_LOG2'(1);
        end
      end
    end
  end

  assign bus.sym_out    = r_sym_out;
  assign bus.sym_valid  = r_sym_valid;
  assign bus.ref_level  = r_ref;
  assign bus.ref_update = r_ref_update;

`ifdef RCV_SLICER_ERR_EN
  logic signed [WIDTH-1:0] w_level;
  logic signed [WIDTH:0]   w_err_wide;
  logic signed [WIDTH-1:0] r_err;

  assign w_level    = w_outer ? w_three : w_half;
  assign w_err_wide = w_neg ? ({r_x_sym[WIDTH-1], r_x_sym} + {w_level[WIDTH-1], w_level})
                            : ({r_x_sym[WIDTH-1], r_x_sym} - {w_level[WIDTH-1], w_level});

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_err <= '0;
    end else if (r_cap_v) begin
      r_err <= sat(w_err_wide);
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = '0;
`endif
endmodule

// File: tb/tb_rcv_slicer_4ask.sv
// Scoreboard bench for rcv_slicer_4ask: stimulus pushes expected decisions from an arithmetic model,
// a negedge monitor pops and compares whenever sym_valid is seen.
module tb_rcv_slicer_4ask;
  localparam int WIDTH    = 18;
  localparam int SPS      = 4;
  localparam int ACC_LOG2 = 2;
  localparam int REF_INIT = 49152;
  localparam int NSYM     = 1 << ACC_LOG2;
  localparam int MAXV     = 131071;
  localparam int MINV     = -131072;

  logic sys_clk = 1'b0;
  logic reset   = 1'b0;

  rcv_slicer_4ask_if #(.WIDTH(WIDTH), .SPS(SPS)) bus ();

  rcv_slicer_4ask #(
    .WIDTH(WIDTH), .SPS(SPS), .ACC_LOG2(ACC_LOG2), .REF_INIT(REF_INIT)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int edge_cnt = 0;
  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [1:0] sym;
    int         err;
    int         refl;
    bit         upd;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: level, running |x| sum, symbols in block, samples since the symbol strobe.
  int m_ref, m_acc, m_cnt, m_idx;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic model_reset();
    m_ref = REF_INIT;
    m_acc = 0;
    m_cnt = 0;
    m_idx = 0;
  endtask

  task automatic model_capture(input int x);
    exp_t e;
    int ax, half, three, level;
    bit pos, outer;
    ax    = (x == MINV) ? MAXV : ((x < 0) ? -x : x);
    half  = m_ref / 2;
    three = sat(m_ref + half);
    pos   = (x >= 0);
    outer = (ax >= m_ref);
    e.sym = {pos, (pos ? outer : !outer)};
    level = outer ? three : half;
    if (!pos) level = -level;
`ifdef RCV_SLICER_ERR_EN
    e.err = sat(x - level);
`else
    e.err = 0;
`endif
    m_acc += ax;
    m_cnt++;
    e.upd = 1'b0;
    if (m_cnt == NSYM) begin
      m_ref = m_acc / NSYM;
      m_acc = 0;
      m_cnt = 0;
      e.upd = 1'b1;
    end
    e.refl = m_ref;
    e.due  = edge_cnt + 2;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge: drives one cycle of inputs and advances to after the next edge.
  task automatic step(input bit sam, input bit sym, input int x, input int ph);
    int p;
    bus.sam_clk_en = sam;
    bus.sym_clk_en = sym;
    bus.x_in       = x[WIDTH-1:0];
    bus.phase_sel  = ph[1:0];
    if (sam) begin
      p     = sym ? 0 : m_idx;
      m_idx = (p + 1) % SPS;
      if (p == ph) model_capture(x);
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sym_out"}, int'(bus.sym_out), 0);
    check({tag, "_sym_valid"}, int'(bus.sym_valid), 0);
    check({tag, "_ref_level"}, int'(bus.ref_level), REF_INIT);
    check({tag, "_ref_update"}, int'(bus.ref_update), 0);
    check({tag, "_err"}, int'(bus.err), 0);
  endtask

  // Drains pending decisions, then asserts reset between edges and checks the outputs at once.
  task automatic async_reset(input string tag);
    idle(3);
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    #2;
    reset = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor
  exp_t mon_e;
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (bus.ref_update && !bus.sym_valid) check("ref_update_without_valid", 1, 0);
      if (bus.sym_valid) begin
        check("valid_has_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("latency_edge", edge_cnt, mon_e.due);
          check("sym_out", int'(bus.sym_out), int'(mon_e.sym));
          check("err", int'(bus.err), mon_e.err);
          check("ref_level", int'(bus.ref_level), mon_e.refl);
          check("ref_update", int'(bus.ref_update), int'(mon_e.upd));
          $display("txn edge=%0d sym=%b err=%0d ref=%0d upd=%0d", edge_cnt, bus.sym_out,
                   bus.err, bus.ref_level, bus.ref_update);
        end
      end
    end
  end

  int tags[4] = '{-100000, -10000, 10000, 100000};
  int specials[6] = '{-131072, 131071, 0, 49152, -49152, 1};

  initial begin
    int sel, x, sam_n, t;
    bit sam, sym;
    bus.sam_clk_en = 1'b0;
    bus.sym_clk_en = 1'b0;
    bus.x_in       = '0;
    bus.phase_sel  = '0;
    model_reset();
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("por");
    repeat (2) @(posedge sys_clk);
    #1;
    reset = 1'b0;

    // Level/err cases at REF_INIT, back-to-back (a symbol strobe on every sample)
    step(1, 1, 80000, 0);
    step(1, 1, -20000, 0);
    step(1, 1, 0, 0);
    step(1, 1, 49152, 0);
    step(1, 1, 65536, 0);
    step(1, 1, 65536, 0);

    // Mid-block reset with a non-initial reference level
    async_reset("midblk");
    step(1, 1, -131072, 0);
    step(1, 1, 65536, 0);
    step(1, 1, -65536, 0);
    step(1, 1, 65536, 0);
    for (int i = 0; i < 5; i++) step(1, 1, (i % 2 == 0) ? 65536 : -65536, 0);
    idle(3);

    // Phase selection with phase-tagged samples and gaps between sample strobes
    async_reset("phase");
    sel = 2;
    for (int s = 0; s < 8; s++) begin
      for (int ph = 0; ph < SPS; ph++) begin
        if (s == 4 && ph == 1) sel = 3;
        x = tags[ph] + ((tags[ph] > 0) ? int'($urandom_range(0, 999)) : -int'($urandom_range(0, 999)));
        step(1, ph == 0, x, sel);
        if ($urandom_range(0, 2) == 0) step(0, 0, int'($urandom_range(0, 262143)) - 131072, sel);
      end
    end

    // Randomized traffic
    sel   = 0;
    sam_n = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 60 == 0) sel = int'($urandom_range(0, 3));
      sam = ($urandom_range(0, 3) != 0);
      sym = 1'b0;
      if (sam) begin
        sym   = (sam_n % SPS == 0) || ($urandom_range(0, 15) == 0);
        sam_n = sym ? 1 : sam_n + 1;
      end
      if ($urandom_range(0, 4) == 0) x = specials[$urandom_range(0, 5)];
      else if ($urandom_range(0, 5) == 0) x = m_ref + int'($urandom_range(0, 2)) - 1;
      else x = int'($urandom_range(0, 262143)) - 131072;
      step(sam, sym, x, sel);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      idle(1);
      t++;
    end
    idle(2);
    check("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
